// File: rtl/mmwave_pkg.sv
// Shared types for the chirp framer: FSM encoding, stream word width, sync word.
// Optional checksum trailer is enabled by MMWAVE_FRAMER_CHECKSUM_EN.
package mmwave_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 16'hA55A;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_CAPTURE,
    ST_CSUM
  } state_e;

endpackage

// File: rtl/mmwave_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with free-entry count.
// Output reads as zero while empty.
module mmwave_sync_fifo
  import mmwave_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      free_o
);

  localparam int CW = AW + 1;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign full_o    = (r_cnt == DEPTH_C);
  assign empty_o   = (r_cnt == '0);
  assign free_o    = DEPTH_C - r_cnt;
  assign w_wr      = wr_en_i && !full_o;
  assign w_rd      = rd_en_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mmwave_chirp_framer.sv
// Chirp-synchronous multi-channel capture framer feeding a valid/ready stream.
// Define MMWAVE_FRAMER_CHECKSUM_EN to append a checksum word to every frame.
module mmwave_chirp_framer
  import mmwave_pkg::*;
#(
  parameter int    NUM_CH            = 2,
  parameter int    DATA_W            = 13,
  parameter int    SAMPLES_PER_CHIRP = 256,
  parameter int    FIFO_DEPTH        = 1024,
  parameter word_t SYNC_WORD         = SYNC_WORD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     chirp_start_i,
  input  logic [4:0]               chirp_num_i,
  input  logic [15:0]              down_psc_i,
  input  logic                     sample_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] sample_data_i,
  output logic [15:0]              m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic                     m_last_o,
  output logic                     busy_o,
  output logic                     overflow_o
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int SW  = $clog2(SAMPLES_PER_CHIRP + 1);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef MMWAVE_FRAMER_CHECKSUM_EN
  localparam int RSV = 1;
`else
  localparam int RSV = 0;
`endif

  state_e                   r_state;
  state_e                   w_next;
  logic [4:0]               r_idx;
  logic [4:0]               r_frame_idx;
  logic [15:0]              r_dec;
  logic [SW-1:0]            r_acc;
  logic                     r_ser_busy;
  logic [CHW-1:0]           r_ser_ch;
  logic [NUM_CH*DATA_W-1:0] r_shadow;
  logic                     r_ovf;
`ifdef MMWAVE_FRAMER_CHECKSUM_EN
  word_t                    r_csum;
`endif

  logic          w_idle;
  logic          w_start;
  logic          w_skip;
  logic          w_sel;
  logic          w_accept;
  logic          w_drop;
  logic          w_ser_last;
  logic          w_frame_done;
  logic [4:0]    w_idx_nx;
  word_t         w_samp;
  logic          w_wr;
  logic [16:0]   w_wdata;
  logic [16:0]   w_rdata;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_free;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_start = w_idle && chirp_start_i && en_i
                && (int'(w_free) >= 2 + RSV);
  assign w_skip  = w_idle && chirp_start_i && !w_start;

  // Decimation picks the set; space/serializer decide if it survives.
  assign w_sel    = (r_state == ST_CAPTURE) && sample_valid_i
                 && (r_dec == '0)
                 && (int'(r_acc) < SAMPLES_PER_CHIRP);
  assign w_accept = w_sel && !r_ser_busy
                 && (int'(w_free) >= NUM_CH + RSV);
  assign w_drop   = w_sel && !w_accept;

  assign w_ser_last   = r_ser_busy && (r_ser_ch == CHW'(NUM_CH - 1));
  assign w_frame_done = w_ser_last
                     && (int'(r_acc) == SAMPLES_PER_CHIRP);
  assign w_samp       = WORD_W'(r_shadow[DATA_W-1:0]);
  assign w_idx_nx     = (int'(r_idx) + 1 >= int'(chirp_num_i))
                      ? 5'd0 : r_idx + 5'd1;

  always_comb begin
    w_next  = r_state;
    w_wr    = 1'b0;
    w_wdata = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_HDR0;
      end
      ST_HDR0: begin
        w_wr    = 1'b1;
        w_wdata = {1'b0, SYNC_WORD};
        w_next  = ST_HDR1;
      end
      ST_HDR1: begin
        w_wr    = 1'b1;
        w_wdata = {1'b0, 3'b000, r_frame_idx, 8'(NUM_CH)};
        w_next  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (r_ser_busy) begin
          w_wr    = 1'b1;
          w_wdata = {(RSV == 0) && w_frame_done, w_samp};
        end
        if (w_frame_done) begin
`ifdef MMWAVE_FRAMER_CHECKSUM_EN
          w_next = ST_CSUM;
`else
          w_next = ST_IDLE;
`endif
        end
      end
      ST_CSUM: begin
`ifdef MMWAVE_FRAMER_CHECKSUM_EN
        w_wr    = 1'b1;
        w_wdata = {1'b1, r_csum};
`endif
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_frame_idx <= '0;
      r_dec       <= '0;
      r_acc       <= '0;
      r_ser_busy  <= 1'b0;
      r_ser_ch    <= '0;
      r_shadow    <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle && chirp_start_i) r_idx <= w_idx_nx;
      if (w_start) begin
        r_frame_idx <= r_idx;
        r_acc       <= '0;
      end
      if (r_state == ST_HDR1) begin
        r_dec <= '0;
      end else if (r_state == ST_CAPTURE && sample_valid_i) begin
        r_dec <= (r_dec == '0) ? down_psc_i : r_dec - 16'd1;
      end
      if (w_accept) begin
        r_acc      <= r_acc + SW'(1);
        r_ser_busy <= 1'b1;
        r_ser_ch   <= '0;
        r_shadow   <= sample_data_i;
      end else if (r_ser_busy) begin
        r_shadow <= r_shadow >> DATA_W;
        r_ser_ch <= r_ser_ch + CHW'(1);
        if (w_ser_last) r_ser_busy <= 1'b0;
      end
      if (!en_i) r_ovf <= 1'b0;
      else if (w_skip || w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef MMWAVE_FRAMER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_csum <= '0;
    else if (w_start) r_csum <= '0;
    else if (r_state == ST_CAPTURE && r_ser_busy) r_csum <= r_csum + w_samp;
  end
`endif

  mmwave_sync_fifo #(
    .WIDTH (17),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (w_wr && !w_full),
    .wr_data_i (w_wdata),
    .rd_en_i   (m_valid_o && m_ready_i),
    .rd_data_o (w_rdata),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .free_o    (w_free)
  );

  assign m_valid_o  = !w_empty;
  assign m_data_o   = w_rdata[15:0];
  assign m_last_o   = w_rdata[16];
  assign busy_o     = !w_idle;
  assign overflow_o = r_ovf;

endmodule
